bus_arb_4: RTL and testbench
============================

BUS_ARB_4 -- requirements
Module: bus_arb_4

Interface
REQ-001 Parameter DATA_W, default 32, payload width; 32 is the only supported value because the selected-data path reuses the 32-bit 4-input mux.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req  input  4  request vector; bit i is requester i (0=a, 1=b, 2=c, 3=d).
REQ-005 in_a, in_b, in_c, in_d  input  32 each  requester payloads; each is held stable while its req bit is high.
REQ-006 gnt  output  4  one-hot grant; single-cycle pulse in the capture cycle.
REQ-007 out_valid  output  1  out_data is valid.
REQ-008 out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high.
REQ-009 out_data  output  32  registered payload of the granted requester.
REQ-010 out_src  output  2  index of the requester whose payload is in out_data.

Function
REQ-011 The block SHALL arbitrate four requesters onto one output channel, with a one-entry output register.
REQ-012 FSM states SHALL be IDLE (out_valid=0) and FULL (out_valid=1).
REQ-013 A capture SHALL occur on an edge where any req bit is high and the register is free: state IDLE, or state FULL with out_ready=1.
REQ-014 On capture: the winner w is selected round-robin; gnt[w]=1 for that cycle; out_data<=payload w through the mux with mux_s=w; out_src<=w; state<=FULL.
REQ-015 Round-robin SHALL search from pointer ptr upward, wrapping 3->0. The first set req bit wins. ptr<=(w+1) mod 4 after each capture; ptr is unchanged when nothing is captured.
REQ-016 gnt SHALL be combinational from req, ptr and state, and SHALL be 4'b0000 whenever no capture occurs.
REQ-017 In FULL with out_ready=0: out_data, out_src and out_valid SHALL hold, and gnt=0 regardless of req.
REQ-018 In FULL with out_ready=1 and req=0: state<=IDLE; out_data and out_src hold their stale values.
REQ-019 In FULL with out_ready=1 and req!=0: handoff and a new capture occur in the same edge; state stays FULL. This gives a sustained throughput of 1 transfer/cycle.
REQ-020 Latency SHALL be one cycle from a req asserted in IDLE to out_valid=1.
REQ-021 A requester SHALL drop req only after seeing its gnt. A req that drops before grant is simply never served, with no error indication.
REQ-022 Simultaneous requests from all four requesters SHALL be served in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4). No requester waits more than 3 other grants.

Reset
REQ-023 While rst_n=0: state=IDLE, ptr=0, out_valid=0, out_data=32'h0, out_src=2'b00, gnt=4'b0000.
REQ-024 Reset asserted mid-transfer SHALL discard the held payload immediately (asynchronously), with no handshake.
REQ-025 The first edge after rst_n deasserts SHALL behave as IDLE.

Structure
REQ-026 The state encoding (IDLE=1'b0, FULL=1'b1) and the requester-index constants (REQ_A..REQ_D = 2'd0..2'd3) SHALL live in the shared define.vh.
REQ-027 The block SHALL instantiate one mux_4in (mux_s=winner index, mux_in_a..d=in_a..in_d) as its only sub-module.
REQ-028 The round-robin priority search and the FSM SHALL live in bus_arb_4 itself; no other sub-modules.

Verification
REQ-029 Reset, then req=4'b0100, in_c=32'hCAFE0002, out_ready=1 -> gnt=4'b0100 in cycle 0; out_valid=1, out_data=32'hCAFE0002, out_src=2 in cycle 1; ptr=3.
REQ-030 req=4'b1111 held, out_ready=1, ptr=0 -> gnt sequence 0001, 0010, 0100, 1000, 0001; out_valid stays high throughout; out_src follows 0,1,2,3,0.
REQ-031 FULL with out_ready=0 for 5 cycles and req=4'b0011 -> out_data/out_src frozen and gnt=0; the first cycle with out_ready=1 grants the next requester after the previously served one.
REQ-032 ptr=3, req=4'b0001 -> wrap-around: gnt=4'b0001; ptr becomes 1.
REQ-033 FULL, out_ready=1, req=0 -> out_valid falls in the next cycle; out_data unchanged.
REQ-034 rst_n pulsed low mid-cycle while FULL -> out_valid, out_data and gnt clear immediately, before the next clk edge; after release, req=4'b1000 is granted with ptr reset to 0.

Source files
------------

// File: rtl/bus_arb_4_pkg.sv
// bus_arb_4_pkg: shared state encoding and requester indices for the four-way arbiter
package bus_arb_4_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [1:0] REQ_A = 2'd0;
    localparam logic [1:0] REQ_B = 2'd1;
    localparam logic [1:0] REQ_C = 2'd2;
    localparam logic [1:0] REQ_D = 2'd3;

    localparam int N_REQ = 4;

endpackage

// File: rtl/bus_arb_4_mux.sv
// mux_4in: 4-input payload selector indexed by requester number
module mux_4in
    import bus_arb_4_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   mux_s,
    input  logic [W-1:0] mux_in_a,
    input  logic [W-1:0] mux_in_b,
    input  logic [W-1:0] mux_in_c,
    input  logic [W-1:0] mux_in_d,
    output logic [W-1:0] mux_out
);

    // route the selected requester's payload to the output
    always_comb begin
        mux_out = mux_s == REQ_A ? mux_in_a :
                  mux_s == REQ_B ? mux_in_b :
                  mux_s == REQ_C ? mux_in_c : mux_in_d;
    end

endmodule

// File: rtl/bus_arb_4.sv
// bus_arb_4: round-robin arbiter of four requesters onto one registered valid/ready channel
module bus_arb_4
    import bus_arb_4_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    input  logic [DATA_W-1:0] in_d,
    output logic [3:0]        gnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src
);

    state_t            state, state_nxt;
    logic [1:0]        ptr;
    logic [1:0]        win;
    logic [1:0]        idx;
    logic              capture;
    logic [DATA_W-1:0] mux_out;

    mux_4in #(.W(DATA_W)) u_mux (
        .mux_s    (win),
        .mux_in_a (in_a),
        .mux_in_b (in_b),
        .mux_in_c (in_c),
        .mux_in_d (in_d),
        .mux_out  (mux_out)
    );

    // round-robin search: scan farthest offset first so the nearest set bit from ptr wins
    always_comb begin
        win = ptr;
        idx = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) win = idx;
        end
    end

    // capture when a request is pending and the output register is free; gnt masked during reset
    always_comb begin
        capture   = rst_n && (|req) && (state == IDLE || out_ready);
        gnt       = capture ? 4'(4'b0001 << win) : 4'b0000;
        out_valid = state == FULL;
        state_nxt = capture ? FULL : (state == FULL && out_ready) ? IDLE : state;
    end

    // state, pointer and output register; reset drops any held payload immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= REQ_A;
            out_data <= '0;
            out_src  <= REQ_A;
        end else begin
            state <= state_nxt;
            if (capture) begin
                ptr      <= win + 2'd1;
                out_data <= mux_out;
                out_src  <= win;
            end
        end
    end

endmodule

// File: tb/tb_bus_arb_4.sv
// tb_bus_arb_4: scoreboard bench for the four-way round-robin arbiter
module tb_bus_arb_4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b0;
    logic [31:0] in_a, in_b, in_c, in_d;
    logic [3:0]  gnt;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  out_src;

    logic [31:0] pay [4] = '{32'hA0A0_0000, 32'hB1B1_0001, 32'hCAFE_0002, 32'hD3D3_0003};
    logic [33:0] sb [$];
    logic [33:0] last_m;
    logic [1:0]  ptr_m;
    int          n_vec = 0;
    int          n_err = 0;

    assign in_a = pay[0];
    assign in_b = pay[1];
    assign in_c = pay[2];
    assign in_d = pay[3];

    always #5 clk = ~clk;

    bus_arb_4 #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] i;
            i = p + 2'(k);
            if (r[i]) return i;
        end
        return p;
    endfunction

    task automatic check_out();
        check("out_valid", 36'(out_valid), 36'(sb.size() != 0));
        check("out_src", 36'(out_src), 36'(last_m[33:32]));
        check("out_data", 36'(out_data), 36'(last_m[31:0]));
    endtask

    task automatic model_reset();
        sb.delete();
        last_m = '0;
        ptr_m  = 2'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'b0;
        model_reset();
        #3;
        check("rst_gnt", 36'(gnt), 36'h0);
        check_out();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cyc(input logic [3:0] r, input logic rdy);
        logic       full, cap;
        logic [1:0] w;
        req = r;
        out_ready = rdy;
        #1;
        full = sb.size() != 0;
        cap  = (|r) && (!full || rdy);
        w    = pick(r, ptr_m);
        check("gnt", 36'(gnt), cap ? 36'(4'b0001 << w) : 36'h0);
        @(posedge clk);
        if (full && rdy) void'(sb.pop_front());
        if (cap) begin
            last_m = {w, pay[w]};
            sb.push_back(last_m);
            ptr_m = w + 2'd1;
        end
        #1;
        check_out();
    endtask

    initial begin
        do_reset();
        cyc(4'b0100, 1'b1);
        cyc(4'b1111, 1'b1);
        cyc(4'b0000, 1'b1);

        do_reset();
        repeat (5) cyc(4'b1111, 1'b1);

        cyc(4'b0011, 1'b1);
        repeat (5) cyc(4'b0011, 1'b0);
        cyc(4'b0011, 1'b1);
        cyc(4'b0011, 1'b1);

        do_reset();
        cyc(4'b0100, 1'b1);
        cyc(4'b0001, 1'b1);
        cyc(4'b0011, 1'b1);
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b1);

        cyc(4'b0110, 1'b1);
        req = 4'b1000;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_gnt", 36'(gnt), 36'h0);
        check_out();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'b1000, 1'b1);
        cyc(4'b1111, 1'b1);

        for (int n = 0; n < 300; n++) begin
            if (n % 50 == 0 && sb.size() == 0 && req == 4'b0)
                pay[n % 4] = $urandom;
            cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        cyc(4'b0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
